// File: rtl/div_ctrl_pkg.sv
// Shared types, default widths and factor helper for the div_ctrl clock-enable generator.
package div_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOPPING
    } state_t;

    localparam int CTR_W_DEF = 24;
    localparam int CNT_W_DEF = 16;

    // Width the factor helper works in; divide factors up to 32 bits are supported.
    localparam int HALF_FN_W = 32;

    // Half-period for a divide factor: div>>1, never below 1 (div<2 behaves as div=2).
    function automatic logic [HALF_FN_W-1:0] clamp_half(input logic [HALF_FN_W-1:0] div);
        logic [HALF_FN_W-1:0] h;
        h = div >> 1;
        return (h == '0) ? HALF_FN_W'(1) : h;
    endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// Control/config/output bundle of div_ctrl.
// With DIV_CTRL_TICK_COUNT_EN defined the bundle also carries tick_count.
interface div_ctrl_if
    import div_ctrl_pkg::*;
#(
    parameter int CTR_W = CTR_W_DEF,
    parameter int CNT_W = CNT_W_DEF
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CTR_W-1:0] cfg_div;
    logic             start;
    logic             stop;
    logic [CNT_W-1:0] burst_len;
    logic             clk_out;
    logic             tick;
    logic             busy;
    logic             done;
`ifdef DIV_CTRL_TICK_COUNT_EN
    logic [CNT_W-1:0] tick_count;

    modport master (
        output cfg_valid, cfg_div, start, stop, burst_len,
        input  cfg_ready, clk_out, tick, busy, done, tick_count
    );
    modport slave (
        input  cfg_valid, cfg_div, start, stop, burst_len,
        output cfg_ready, clk_out, tick, busy, done, tick_count
    );
`else
    modport master (
        output cfg_valid, cfg_div, start, stop, burst_len,
        input  cfg_ready, clk_out, tick, busy, done
    );
    modport slave (
        input  cfg_valid, cfg_div, start, stop, burst_len,
        output cfg_ready, clk_out, tick, busy, done
    );
`endif
endinterface

// File: rtl/div_ctrl_half_period_ctr.sv
// Half-period counter: counts 1..half while enabled and flags the cycle where hc==half.
module half_period_ctr #(
    parameter int CTR_W = 24
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [CTR_W-1:0] half,
    output logic             wrap
);
    logic [CTR_W-1:0] hc;

    // NOTE: wrap is combinational so the parent can register clk_out on the same edge hc restarts.
    assign wrap = en && (hc == half);

    // Count up while enabled, restart at 1 on wrap, hold at 1 while cleared.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            hc <= CTR_W'(1);
        end else if (clr) begin
            hc <= CTR_W'(1);
        end else if (en) begin
            hc <= wrap ? CTR_W'(1) : hc + CTR_W'(1);
        end
    end

endmodule

// File: rtl/div_ctrl.sv
// div_ctrl: runtime-programmable divided clock / tick generator with start, stop and burst control.
// Optional feature macro: DIV_CTRL_TICK_COUNT_EN (adds a saturating tick_count output).
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int CTR_W       = CTR_W_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = 2
) (
    input logic       clk_in,
    input logic       rst_n,
    div_ctrl_if.slave bus
);
    localparam logic [CTR_W-1:0] DEFAULT_HALF = CTR_W'(clamp_half(HALF_FN_W'(DEFAULT_DIV)));

    state_t           state;
    logic [CTR_W-1:0] active_half;
    logic [CTR_W-1:0] shadow;
    logic [CTR_W-1:0] shadow_half;
    logic             shadow_full;
    logic [CNT_W-1:0] burst_cnt;
    logic             burst_mode;
    logic             clk_out_q;
    logic             tick_q;
    logic             done_q;
    logic             wrap;

    assign shadow_half = CTR_W'(clamp_half(HALF_FN_W'(shadow)));

    half_period_ctr #(.CTR_W(CTR_W)) u_hpc (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .en     (state != IDLE),
        .clr    (state == IDLE),
        .half   (active_half),
        .wrap   (wrap)
    );

    // Sequencer: state, divided output, strobes, burst count and factor shadow/apply.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            active_half <= DEFAULT_HALF;
            shadow      <= '0;
            shadow_full <= 1'b0;
            burst_cnt   <= '0;
            burst_mode  <= 1'b0;
            clk_out_q   <= 1'b0;
            tick_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // NOTE: strobes default low each cycle; non-blocking keeps later branch writes authoritative.
            tick_q <= 1'b0;
            done_q <= 1'b0;

            if (bus.cfg_valid && !shadow_full) begin
                shadow      <= bus.cfg_div;
                shadow_full <= 1'b1;
            end

            case (state)
                IDLE: begin
                    clk_out_q <= 1'b0;
                    if (shadow_full) begin
                        active_half <= shadow_half;
                        shadow_full <= 1'b0;
                    end
                    if (bus.start && !bus.stop) begin
                        state      <= RUN;
                        clk_out_q  <= 1'b1;
                        tick_q     <= 1'b1;
                        burst_mode <= (bus.burst_len != '0);
                        // The rise issued here already consumes one burst period.
                        burst_cnt  <= bus.burst_len - CNT_W'(1);
                    end
                end

                RUN: begin
                    if (wrap && !clk_out_q) begin
                        // End of a low half: a stop pending here ends without a new rise.
                        if (bus.stop) begin
                            state  <= IDLE;
                            done_q <= 1'b1;
                        end else begin
                            clk_out_q <= 1'b1;
                            tick_q    <= 1'b1;
                            if (burst_mode) begin
                                burst_cnt <= burst_cnt - CNT_W'(1);
                            end
                        end
                    end else if (wrap) begin
                        // Falling toggle: the only point a new factor may take effect mid-run.
                        clk_out_q <= 1'b0;
                        if (shadow_full) begin
                            active_half <= shadow_half;
                            shadow_full <= 1'b0;
                        end
                        if (bus.stop || (burst_mode && burst_cnt == '0)) begin
                            state  <= IDLE;
                            done_q <= 1'b1;
                        end
                    end else if (bus.stop) begin
                        state <= STOPPING;
                    end
                end

                STOPPING: begin
                    if (wrap) begin
                        if (clk_out_q && shadow_full) begin
                            active_half <= shadow_half;
                            shadow_full <= 1'b0;
                        end
                        clk_out_q <= 1'b0;
                        state     <= IDLE;
                        done_q    <= 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cfg_ready = !shadow_full;
    assign bus.clk_out   = clk_out_q;
    assign bus.tick      = tick_q;
    assign bus.done      = done_q;
    assign bus.busy      = (state != IDLE);

`ifdef DIV_CTRL_TICK_COUNT_EN
    logic [CNT_W-1:0] tick_count_q;

    // Tick counter: cleared on start, counts visible ticks, saturates, holds while idle.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            tick_count_q <= '0;
        end else if (state == IDLE && bus.start && !bus.stop) begin
            tick_count_q <= '0;
        end else if (tick_q && tick_count_q != '1) begin
            tick_count_q <= tick_count_q + CNT_W'(1);
        end
    end

    assign bus.tick_count = tick_count_q;
`endif

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: burst vector table plus directed multi-cycle sequences.
module tb_div_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    div_ctrl_if #(.CTR_W(24), .CNT_W(16)) bus ();

    div_ctrl #(.CTR_W(24), .CNT_W(16), .DEFAULT_DIV(2)) dut (
        .clk_in (clk),
        .rst_n  (rst_n),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] div;
        logic [15:0] blen;
        int          half;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_config(input logic [23:0] div);
        bus.cfg_div   = div;
        bus.cfg_valid = 1'b1;
        step();
        bus.cfg_valid = 1'b0;
        check($sformatf("cfg_ready low after accept div=%0d", div), bus.cfg_ready, 0);
        step();
        check($sformatf("cfg_ready high after apply div=%0d", div), bus.cfg_ready, 1);
    endtask

    // Start a burst and measure it until done; optionally pulse start mid-run at sample start_at.
    task automatic run_burst(input string name, input logic [15:0] blen, input int half, input int start_at);
        int n;
        int highs;
        int ticks;
        int b;
        b = int'(blen);
        n = 0;
        highs = 0;
        ticks = 0;
        bus.burst_len = blen;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check({name, " first tick"}, bus.tick, 1);
        check({name, " busy"}, bus.busy, 1);
        while (!bus.done && n < 400) begin
            if (n == start_at) begin
                bus.start = 1'b1;
                bus.burst_len = 16'd5;
            end else begin
                bus.start = 1'b0;
            end
            highs += int'(bus.clk_out);
            ticks += int'(bus.tick);
            n++;
            step();
        end
        bus.start = 1'b0;
        check({name, " done seen"}, bus.done, 1);
        check({name, " cycles to done"}, n, (2 * b - 1) * half);
        check({name, " high cycles"}, highs, b * half);
        check({name, " ticks"}, ticks, b);
        check({name, " idle at done"}, bus.busy, 0);
        check({name, " clk_out low at done"}, bus.clk_out, 0);
        step();
        check({name, " done single pulse"}, bus.done, 0);
    endtask

    initial begin
        int highs;
        int ticks;
        int dones;
        int busy_cnt;
        int pat_err;
        int n;
        logic clk_hist[18];
        logic rdy_hist[18];
        int falls[$];

        checks = 0;
        failures = 0;
        vecs[0] = '{div: 24'd6,  blen: 16'd3, half: 3};
        vecs[1] = '{div: 24'd1,  blen: 16'd2, half: 1};
        vecs[2] = '{div: 24'd7,  blen: 16'd1, half: 3};
        vecs[3] = '{div: 24'd0,  blen: 16'd2, half: 1};
        vecs[4] = '{div: 24'd5,  blen: 16'd3, half: 2};
        vecs[5] = '{div: 24'd10, blen: 16'd1, half: 5};

        rst_n = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_div = '0;
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.burst_len = '0;
        repeat (3) step();
        check("reset clk_out", bus.clk_out, 0);
        check("reset tick", bus.tick, 0);
        check("reset done", bus.done, 0);
        check("reset busy", bus.busy, 0);
        check("reset cfg_ready", bus.cfg_ready, 1);
        rst_n = 1'b1;
        step();

        // Continuous run at the default factor.
        highs = 0; ticks = 0; dones = 0; busy_cnt = 0; pat_err = 0;
        bus.burst_len = '0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.clk_out !== ((i % 2) == 0)) pat_err++;
            highs += int'(bus.clk_out);
            ticks += int'(bus.tick);
            dones += int'(bus.done);
            busy_cnt += int'(bus.busy);
            step();
        end
        check("cont toggle pattern errors", pat_err, 0);
        check("cont high cycles", highs, 10);
        check("cont ticks", ticks, 10);
        check("cont no done", dones, 0);
        check("cont busy cycles", busy_cnt, 20);
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        check("cont stop done", bus.done, 1);
        check("cont stop clk_out", bus.clk_out, 0);
        check("cont stop tick", bus.tick, 0);
        step();

        // Burst vector table.
        foreach (vecs[k]) begin
            do_config(vecs[k].div);
            run_burst($sformatf("vec%0d div=%0d", k, vecs[k].div), vecs[k].blen, vecs[k].half, -1);
        end

        // New factor written mid high phase while running at div=4.
        do_config(24'd4);
        bus.burst_len = '0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 18; i++) begin
            clk_hist[i] = bus.clk_out;
            rdy_hist[i] = bus.cfg_ready;
            if (i == 4) begin
                bus.cfg_div = 24'd10;
                bus.cfg_valid = 1'b1;
            end else begin
                bus.cfg_valid = 1'b0;
            end
            step();
        end
        bus.cfg_valid = 1'b0;
        for (int i = 1; i < 18; i++) begin
            if (clk_hist[i-1] && !clk_hist[i]) falls.push_back(i);
        end
        check("midcfg fall count", falls.size(), 3);
        if (falls.size() >= 3) begin
            check("midcfg period before apply", falls[1] - falls[0], 4);
            check("midcfg period after apply", falls[2] - falls[1], 10);
        end else begin
            check("midcfg fall list too short", falls.size(), 3);
        end
        check("midcfg ready before write", rdy_hist[4], 1);
        check("midcfg ready while pending", rdy_hist[5], 0);
        check("midcfg ready after apply", rdy_hist[6], 1);
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        n = 0; highs = 0; ticks = 0;
        while (!bus.done && n < 50) begin
            highs += int'(bus.clk_out);
            ticks += int'(bus.tick);
            n++;
            step();
        end
        check("midcfg stop done", bus.done, 1);
        check("midcfg stop stays low", highs, 0);
        check("midcfg stop no tick", ticks, 0);
        step();

        // Stop one cycle after a rising toggle at div=8.
        do_config(24'd8);
        bus.burst_len = '0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 9; i++) step();
        check("stop8 high before stop", bus.clk_out, 1);
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        n = 0; highs = 0; ticks = 0;
        while (!bus.done && n < 50) begin
            highs += int'(bus.clk_out);
            ticks += int'(bus.tick);
            n++;
            step();
        end
        check("stop8 done", bus.done, 1);
        check("stop8 cycles to done", n, 2);
        check("stop8 high until scheduled fall", highs, 2);
        check("stop8 no tick", ticks, 0);
        check("stop8 clk_out low", bus.clk_out, 0);
        check("stop8 idle", bus.busy, 0);
        step();
        check("stop8 done single pulse", bus.done, 0);

        // start while running is ignored.
        run_burst("ignore start div=8", 16'd1, 4, 2);

        // start together with stop in IDLE does nothing.
        busy_cnt = 0; highs = 0; dones = 0;
        bus.start = 1'b1;
        bus.stop = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            busy_cnt += int'(bus.busy);
            highs += int'(bus.clk_out);
            dones += int'(bus.done);
        end
        bus.start = 1'b0;
        bus.stop = 1'b0;
        check("start+stop busy", busy_cnt, 0);
        check("start+stop clk_out", highs, 0);
        check("start+stop done", dones, 0);

        // Reset mid high phase with a pending factor.
        bus.burst_len = '0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.cfg_div = 24'd20;
        bus.cfg_valid = 1'b1;
        step();
        bus.cfg_valid = 1'b0;
        check("rst pending ready low", bus.cfg_ready, 0);
        check("rst pending clk high", bus.clk_out, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst clk_out", bus.clk_out, 0);
        check("async rst tick", bus.tick, 0);
        check("async rst busy", bus.busy, 0);
        check("async rst cfg_ready", bus.cfg_ready, 1);
        step();
        rst_n = 1'b1;
        step();
        check("post rst cfg_ready", bus.cfg_ready, 1);
        run_burst("post rst default div", 16'd1, 1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
